// File: rtl/atm_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : atm_session_ctrl
// Description : ATM session/transaction controller. Sequences card, PIN and
//               menu operations, owns the account balance, enforces PIN
//               retry lockout and inactivity timeout, and handshakes with
//               the cash dispenser (disp_req held until disp_ack).
//               Optional per-session withdrawal cap: ATM_WD_LIMIT_EN
//               (adds the WD_LIMIT parameter, the wd_total register and
//               status 6 = LIMIT).
// Revision    : 1.0 - initial release
// ============================================================================
module atm_session_ctrl #(
  parameter int AMT_W         = 16,
  parameter int INIT_BALANCE  = 1000,
  parameter int MAX_PIN_TRIES = 3,
  parameter int TIMEOUT_CYC   = 255
`ifdef ATM_WD_LIMIT_EN
  ,
  parameter int WD_LIMIT      = 2000
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             card_in,
  input  logic             pin_valid,
  input  logic             pin_ok,
  input  logic             op_valid,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amount,
  output logic             disp_req,
  output logic [AMT_W-1:0] disp_amt,
  input  logic             disp_ack,
  output logic [AMT_W-1:0] balance,
  output logic             card_eject,
  output logic             card_retain,
  output logic             done,
  output logic [2:0]       status,
  output logic             busy
);

  localparam int TRY_W  = (MAX_PIN_TRIES < 2) ? 1 : $clog2(MAX_PIN_TRIES + 1);
  localparam int IDLE_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  localparam logic [AMT_W-1:0]  INIT_BAL_C  = AMT_W'(INIT_BALANCE);
  localparam logic [TRY_W-1:0]  MAX_TRIES_C = TRY_W'(MAX_PIN_TRIES);
  localparam logic [IDLE_W-1:0] IDLE_LIM_C  = IDLE_W'(TIMEOUT_CYC);

  localparam logic [2:0] STAT_OK       = 3'd0;
  localparam logic [2:0] STAT_BAD_PIN  = 3'd1;
  localparam logic [2:0] STAT_LOCKED   = 3'd2;
  localparam logic [2:0] STAT_INSUFF   = 3'd3;
  localparam logic [2:0] STAT_OVERFLOW = 3'd4;
  localparam logic [2:0] STAT_TIMEOUT  = 3'd5;
`ifdef ATM_WD_LIMIT_EN
  localparam logic [2:0]   STAT_LIMIT  = 3'd6;
  localparam logic [AMT_W:0] WD_LIMIT_C = (AMT_W+1)'(WD_LIMIT);
`endif

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PIN_WAIT = 3'd1,
    ST_MENU     = 3'd2,
    ST_CHECK    = 3'd3,
    ST_DISPENSE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [TRY_W-1:0]  tries_q, tries_d, tries_nxt;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d, idle_nxt;
  logic [1:0]        op_q, op_d;
  logic [AMT_W-1:0]  amt_q, amt_d;
  logic              pend_q, pend_d;
  logic [AMT_W-1:0]  balance_q, balance_d;
  logic              disp_req_q, disp_req_d;
  logic [AMT_W-1:0]  disp_amt_q, disp_amt_d;
  logic              card_eject_q, card_eject_d;
  logic              card_retain_q, card_retain_d;
  logic              done_q, done_d;
  logic [2:0]        status_q, status_d;
  logic              busy_q, busy_d;
  logic [AMT_W:0]    dep_sum;
`ifdef ATM_WD_LIMIT_EN
  logic [AMT_W-1:0]  wd_total_q, wd_total_d;
  logic [AMT_W:0]    wd_sum;
`endif

  // Next-state and next-output computation for the whole session FSM.
  // A menu selection is latched first (pend_q) and evaluated in CHECK on the
  // following cycle, so results appear two edges after the op_valid edge.
  always_comb begin
    state_d       = state_q;
    tries_d       = tries_q;
    idle_cnt_d    = idle_cnt_q;
    op_d          = op_q;
    amt_d         = amt_q;
    pend_d        = 1'b0;
    balance_d     = balance_q;
    disp_req_d    = disp_req_q;
    disp_amt_d    = disp_amt_q;
    card_eject_d  = 1'b0;
    card_retain_d = 1'b0;
    done_d        = 1'b0;
    status_d      = status_q;
    tries_nxt     = tries_q + TRY_W'(1);
    idle_nxt      = idle_cnt_q + IDLE_W'(1);
    dep_sum       = {1'b0, balance_q} + {1'b0, amt_q};
`ifdef ATM_WD_LIMIT_EN
    wd_total_d    = wd_total_q;
    wd_sum        = {1'b0, wd_total_q} + {1'b0, amt_q};
`endif

    case (state_q)
      ST_IDLE: begin
        if (card_in) begin
          state_d    = ST_PIN_WAIT;
          tries_d    = '0;
          idle_cnt_d = '0;
`ifdef ATM_WD_LIMIT_EN
          wd_total_d = '0;
`endif
        end
      end

      ST_PIN_WAIT: begin
        if (!card_in) begin
          state_d    = ST_IDLE;
          idle_cnt_d = '0;
        end else if (pin_valid) begin
          idle_cnt_d = '0;
          done_d     = 1'b1;
          if (pin_ok) begin
            state_d  = ST_MENU;
            status_d = STAT_OK;
          end else begin
            tries_d = tries_nxt;
            if (tries_nxt == MAX_TRIES_C) begin
              state_d       = ST_IDLE;
              card_retain_d = 1'b1;
              status_d      = STAT_LOCKED;
            end else begin
              status_d = STAT_BAD_PIN;
            end
          end
        end else if (idle_nxt == IDLE_LIM_C) begin
          state_d      = ST_IDLE;
          idle_cnt_d   = '0;
          card_eject_d = 1'b1;
          done_d       = 1'b1;
          status_d     = STAT_TIMEOUT;
        end else begin
          idle_cnt_d = idle_nxt;
        end
      end

      ST_MENU: begin
        if (!card_in) begin
          state_d    = ST_IDLE;
          idle_cnt_d = '0;
        end else if (pend_q) begin
          state_d    = ST_CHECK;
          idle_cnt_d = '0;
        end else if (op_valid) begin
          idle_cnt_d = '0;
          if (op == 2'b11) begin
            state_d      = ST_IDLE;
            card_eject_d = 1'b1;
            done_d       = 1'b1;
            status_d     = STAT_OK;
          end else begin
            op_d   = op;
            amt_d  = amount;
            pend_d = 1'b1;
          end
        end else if (idle_nxt == IDLE_LIM_C) begin
          state_d      = ST_IDLE;
          idle_cnt_d   = '0;
          card_eject_d = 1'b1;
          done_d       = 1'b1;
          status_d     = STAT_TIMEOUT;
        end else begin
          idle_cnt_d = idle_nxt;
        end
      end

      ST_CHECK: begin
        state_d    = ST_MENU;
        idle_cnt_d = '0;
        case (op_q)
          2'b00: begin
            if ((amt_q == '0) || (amt_q > balance_q)) begin
              done_d   = 1'b1;
              status_d = STAT_INSUFF;
            end
`ifdef ATM_WD_LIMIT_EN
            else if (wd_sum > WD_LIMIT_C) begin
              done_d   = 1'b1;
              status_d = STAT_LIMIT;
            end
`endif
            else begin
              state_d    = ST_DISPENSE;
              disp_amt_d = amt_q;
              disp_req_d = 1'b1;
            end
          end
          2'b01: begin
            done_d = 1'b1;
            if (dep_sum[AMT_W]) begin
              status_d = STAT_OVERFLOW;
            end else begin
              balance_d = dep_sum[AMT_W-1:0];
              status_d  = STAT_OK;
            end
          end
          default: begin
            done_d   = 1'b1;
            status_d = STAT_OK;
          end
        endcase
      end

      ST_DISPENSE: begin
        // No timeout, card removal or abort here: only the dispenser ends it.
        if (disp_ack) begin
          state_d    = ST_MENU;
          idle_cnt_d = '0;
          disp_req_d = 1'b0;
          balance_d  = balance_q - disp_amt_q;
`ifdef ATM_WD_LIMIT_EN
          wd_total_d = wd_total_q + disp_amt_q;
`endif
          done_d     = 1'b1;
          status_d   = STAT_OK;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tries_q       <= '0;
      idle_cnt_q    <= '0;
      op_q          <= '0;
      amt_q         <= '0;
      pend_q        <= 1'b0;
      balance_q     <= INIT_BAL_C;
      disp_req_q    <= 1'b0;
      disp_amt_q    <= '0;
      card_eject_q  <= 1'b0;
      card_retain_q <= 1'b0;
      done_q        <= 1'b0;
      status_q      <= STAT_OK;
      busy_q        <= 1'b0;
`ifdef ATM_WD_LIMIT_EN
      wd_total_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      tries_q       <= tries_d;
      idle_cnt_q    <= idle_cnt_d;
      op_q          <= op_d;
      amt_q         <= amt_d;
      pend_q        <= pend_d;
      balance_q     <= balance_d;
      disp_req_q    <= disp_req_d;
      disp_amt_q    <= disp_amt_d;
      card_eject_q  <= card_eject_d;
      card_retain_q <= card_retain_d;
      done_q        <= done_d;
      status_q      <= status_d;
      busy_q        <= busy_d;
`ifdef ATM_WD_LIMIT_EN
      wd_total_q    <= wd_total_d;
`endif
    end
  end

  assign disp_req    = disp_req_q;
  assign disp_amt    = disp_amt_q;
  assign balance     = balance_q;
  assign card_eject  = card_eject_q;
  assign card_retain = card_retain_q;
  assign done        = done_q;
  assign status      = status_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire
